// File: rtl/t_counter_3bit_pkg.sv
// Shared constants for the 3-bit T-flip-flop sequence counter (0 -> 4 -> 7 -> 2 -> 3 -> 0).
// The is_illegal() helper backs the optional flag enabled by T_COUNTER_3BIT_ILLEGAL_FLAG_EN.
package t_counter_3bit_pkg;

  localparam int unsigned STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  // Main-cycle codes, in visiting order
  localparam state_t ST_0 = 3'd0;
  localparam state_t ST_4 = 3'd4;
  localparam state_t ST_7 = 3'd7;
  localparam state_t ST_2 = 3'd2;
  localparam state_t ST_3 = 3'd3;

  // Codes outside the main cycle; each recovers into it after one clock
  localparam state_t ILL_1 = 3'd1;
  localparam state_t ILL_5 = 3'd5;
  localparam state_t ILL_6 = 3'd6;

  function automatic logic is_illegal(input state_t code);
    return (code == ILL_1) || (code == ILL_5) || (code == ILL_6);
  endfunction

endpackage

// File: rtl/t_counter_3bit_if.sv
// Observation bundle for the counter state (and the illegal-code flag when
// T_COUNTER_3BIT_ILLEGAL_FLAG_EN is defined); master drives it, slave observes it.
interface t_counter_3bit_if;
  import t_counter_3bit_pkg::*;

  state_t q;
`ifdef T_COUNTER_3BIT_ILLEGAL_FLAG_EN
  logic   illegal;

  modport master (output q, output illegal);
  modport slave  (input  q, input  illegal);
`else
  modport master (output q);
  modport slave  (input  q);
`endif

endinterface

// File: rtl/t_counter_3bit_t_flip_flop.sv
// Single T flip-flop with asynchronous active-high clear; toggles on rising clk when t is 1.
module t_flip_flop (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/t_counter_3bit.sv
// 3-bit sequence counter 0 -> 4 -> 7 -> 2 -> 3 -> 0 built from three T flip-flops.
// Define T_COUNTER_3BIT_ILLEGAL_FLAG_EN to add the combinational illegal-code output.
module t_counter_3bit
  import t_counter_3bit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
`ifdef T_COUNTER_3BIT_ILLEGAL_FLAG_EN
  output logic               illegal,
`endif
  output logic [STATE_W-1:0] q
);

  logic q0;
  logic q1;
  logic q2;
  logic t0;
  logic t1;
  logic t2;

  // Toggle equations also fold codes 1, 5 and 6 back into the main cycle in one step
  always_comb begin
    t0 = q1 | q2;
    t1 = (q0 & ~q2) | (q2 & ~q1);
    t2 = (~q2 & ~q1) | (q0 & q2);
  end

  t_flip_flop u_ff0 (
    .clk   (clk),
    .reset (reset),
    .t     (t0),
    .q     (q0)
  );

  t_flip_flop u_ff1 (
    .clk   (clk),
    .reset (reset),
    .t     (t1),
    .q     (q1)
  );

  t_flip_flop u_ff2 (
    .clk   (clk),
    .reset (reset),
    .t     (t2),
    .q     (q2)
  );

  assign q = {q2, q1, q0};

`ifdef T_COUNTER_3BIT_ILLEGAL_FLAG_EN
  assign illegal = is_illegal(q);
`endif

endmodule

// File: tb/tb_t_counter_3bit.sv
// Directed, table-driven bench for t_counter_3bit; also checks the illegal flag
// when built with T_COUNTER_3BIT_ILLEGAL_FLAG_EN.
module tb_t_counter_3bit;
  import t_counter_3bit_pkg::*;

  logic clk;
  logic reset;

  t_counter_3bit_if cnt_if ();

  t_counter_3bit dut (
    .clk     (clk),
    .reset   (reset),
`ifdef T_COUNTER_3BIT_ILLEGAL_FLAG_EN
    .illegal (cnt_if.illegal),
`endif
    .q       (cnt_if.q)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [2:0] exp_q;
  } vec_t;

  typedef struct {
    logic [2:0] code;
    logic [2:0] nxt;
    logic [2:0] after;
  } rec_t;

  vec_t vecs[12];
  rec_t recs[3];

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ill(input string name, input logic exp);
`ifdef T_COUNTER_3BIT_ILLEGAL_FLAG_EN
    total++;
    if (cnt_if.illegal !== exp) begin
      bad++;
      $display("FAIL %s: illegal got %b expected %b at %0t", name, cnt_if.illegal, exp, $time);
    end
`else
    if (exp === 1'bx) $display("unreachable %s", name);
`endif
  endtask

  // Hand-written successor table for the main cycle
  function automatic logic [2:0] next_main(input logic [2:0] s);
    case (s)
      3'd0:    return 3'd4;
      3'd4:    return 3'd7;
      3'd7:    return 3'd2;
      3'd2:    return 3'd3;
      3'd3:    return 3'd0;
      default: return 3'bxxx;
    endcase
  endfunction

  task automatic force_state(input logic [2:0] code);
    logic b0, b1, b2;
    b0 = code[0];
    b1 = code[1];
    b2 = code[2];
    force dut.u_ff0.q_q = b0;
    force dut.u_ff1.q_q = b1;
    force dut.u_ff2.q_q = b2;
    #1;
    release dut.u_ff0.q_q;
    release dut.u_ff1.q_q;
    release dut.u_ff2.q_q;
  endtask

  initial begin
    logic [2:0] model;
    logic       seen7;

    // {reset, expected q} on successive rising edges after release
    vecs[0]  = '{1'b0, 3'd4};
    vecs[1]  = '{1'b0, 3'd7};
    vecs[2]  = '{1'b0, 3'd2};
    vecs[3]  = '{1'b0, 3'd3};
    vecs[4]  = '{1'b0, 3'd0};
    vecs[5]  = '{1'b0, 3'd4};
    vecs[6]  = '{1'b1, 3'd0};
    vecs[7]  = '{1'b1, 3'd0};
    vecs[8]  = '{1'b0, 3'd4};
    vecs[9]  = '{1'b0, 3'd7};
    vecs[10] = '{1'b0, 3'd2};
    vecs[11] = '{1'b0, 3'd3};

    // {forced code, next q, q one clock later}
    recs[0] = '{3'd1, 3'd7, 3'd2};
    recs[1] = '{3'd5, 3'd2, 3'd3};
    recs[2] = '{3'd6, 3'd7, 3'd2};

    reset = 1'b1;
    #1;
    chk("reset_async", cnt_if.q, 3'd0);
    chk_ill("reset_ill", 1'b0);
    #2;
    chk("reset_hold_edge", cnt_if.q, 3'd0);
    #2;
    reset = 1'b0;

    // Vectors: reset is applied just after a falling edge, q checked on the next one
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d", i), cnt_if.q, vecs[i].exp_q);
      if (vecs[i].exp_q == 3'd0) chk_ill($sformatf("vec%0d_ill", i), 1'b0);
      if (i + 1 < 12) begin
        #1;
        reset = vecs[i+1].rst;
      end
    end

    // Free run: 25 clocks against the successor model
    model = cnt_if.q;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      model = next_main(model);
      chk($sformatf("run%0d", i), cnt_if.q, model);
      chk_ill($sformatf("run%0d_ill", i), 1'b0);
      if (dut.q == 3'd1 || dut.q == 3'd5 || dut.q == 3'd6) begin
        bad++;
        $display("FAIL run%0d_code: got %0d expected main-cycle code", i, cnt_if.q);
      end
    end

    // Async reset while q = 7, between edges
    seen7 = 1'b0;
    for (int i = 0; i < 10 && !seen7; i++) begin
      @(negedge clk);
      if (cnt_if.q == 3'd7) seen7 = 1'b1;
    end
    total++;
    if (!seen7) begin
      bad++;
      $display("FAIL wait_q7: got timeout expected q=7 within 10 clocks");
    end
    #1;
    reset = 1'b1;
    #0.5;
    chk("mid_reset_immediate", cnt_if.q, 3'd0);
    chk_ill("mid_reset_ill", 1'b0);
    @(posedge clk);
    #1;
    chk("mid_reset_hold", cnt_if.q, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_reset_first_edge", cnt_if.q, 3'd4);

    // Unused codes recover in one clock and rejoin the main cycle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      force_state(recs[i].code);
      chk($sformatf("forced%0d", recs[i].code), cnt_if.q, recs[i].code);
      chk_ill($sformatf("forced%0d_ill", recs[i].code), 1'b1);
      @(negedge clk);
      chk($sformatf("recover%0d", recs[i].code), cnt_if.q, recs[i].nxt);
      chk_ill($sformatf("recover%0d_ill", recs[i].code), 1'b0);
      @(negedge clk);
      chk($sformatf("rejoin%0d", recs[i].code), cnt_if.q, recs[i].after);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/t_counter_3bit.md
T_COUNTER_3BIT -- requirements
Module: t_counter_3bit

Interface
REQ-001 Parameters: none; sequence and width are fixed.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 q  output  3  current counter state; q[2] MSB, q[0] LSB; driven directly from the state register.
REQ-005 illegal  output  1  present only when T_COUNTER_3BIT_ILLEGAL_FLAG_EN is defined; high while q holds an unused code.

Function
REQ-006 The block SHALL step through the repeating main cycle 0 -> 4 -> 7 -> 2 -> 3 -> 0, one step per rising clk edge while reset is low.
REQ-007 No enable input exists: the block SHALL advance on every rising clk edge while reset is low.
REQ-008 The state SHALL be held in three T-type flip-flops, one per q bit, each toggling when its T input is 1.
REQ-009 T inputs SHALL be combinational from q only:
- T0 = q1 | q2
- T1 = (q0 & ~q2) | (q2 & ~q1)
- T2 = (~q2 & ~q1) | (q0 & q2)
REQ-010 Unused codes SHALL self-recover in one clock, as fixed by REQ-009:
- 1 -> 7
- 5 -> 2
- 6 -> 7
REQ-011 From any state, the main cycle SHALL be reached within one clock; no lock-up state exists.
REQ-012 q SHALL be registered output only; no combinational path from reset deassertion or clk to q other than the flip-flops.
REQ-013 Latency: q SHALL update at the first rising edge after the edge that samples the prior state; no pipeline stages.

Reset
REQ-014 On reset high, all three flip-flops SHALL clear immediately (q = 0), independent of clk.
REQ-015 While reset is high, q SHALL remain 0 regardless of clock edges.
REQ-016 After reset deasserts, the first rising clk edge SHALL move q from 0 to 4.
REQ-017 Reset asserted mid-cycle (any state, including unused codes) SHALL force q = 0 asynchronously; the sequence restarts from 0.

Configuration
REQ-018 Macro T_COUNTER_3BIT_ILLEGAL_FLAG_EN defined: the block SHALL provide output illegal.
- illegal is combinational from q.
- illegal = 1 iff q is 1, 5 or 6; 0 during reset.
REQ-019 Macro undefined: port illegal and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-020 A shared package t_counter_3bit_pkg SHALL hold:
- the state width constant (3);
- named constants for codes 0, 4, 7, 2, 3;
- the illegal-code set {1, 5, 6}.
REQ-021 One sub-module, t_flip_flop, SHALL be used:
- ports clk, reset (async active-high clear), t, q;
- q toggles on rising clk when t = 1.
- The top instantiates three copies plus the gate-level T logic.

Verification
REQ-022 Reset high at t=0, low at t=5, clk period 4 -> q = 0 during reset; q = 4, 7, 2, 3, 0, 4 on successive rising edges after release.
REQ-023 Free run for 25 clocks after reset release -> q follows the 5-state cycle exactly and returns to 0 every 5 clocks; codes 1/5/6 never appear.
REQ-024 Force the flip-flops to 1, 5 and 6 (via hierarchical force/release) -> next q = 7, 2, 7 respectively, then the main cycle continues.
REQ-025 Assert reset asynchronously between edges while q = 7 -> q = 0 immediately, before the next clk edge; after release the first edge gives q = 4.
REQ-026 With T_COUNTER_3BIT_ILLEGAL_FLAG_EN defined, force q = 5 -> illegal = 1; illegal = 0 in every main-cycle state and during reset.
REQ-027 Compile without the macro -> elaboration succeeds with only clk, reset and q ports, and the REQ-022 sequence is unchanged.
